// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Brief    : Instruction-fetch stage. Owns the PC, reads the instruction SRAM
//            (Ram2), predicts conditional branches with a 16-entry 2-bit BHT
//            and holds the IF/ID pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold_i,
    input  logic        flush_if_i,
    input  logic        jr_i,
    input  logic [15:0] jr_target_i,
    input  logic        prewrong_i,
    input  logic [15:0] redirect_pc_i,
    input  logic        bht_upd_i,
    input  logic [3:0]  bht_upd_idx_i,
    input  logic        bht_upd_taken_i,
    output logic [15:0] instr_o,
    output logic [15:0] pc_o,
    output logic [15:0] pcplus1_o,
    output logic        pred_taken_o,
    output logic [17:0] Ram2Addr,
    inout  wire  [15:0] Ram2Data,
    output logic        Ram2OE,
    output logic        Ram2WE,
    output logic        Ram2EN
);

    localparam logic [4:0] c_op_b     = 5'b00010;
    localparam logic [4:0] c_op_beqz  = 5'b00100;
    localparam logic [4:0] c_op_bnez  = 5'b00101;
    localparam logic [4:0] c_op_bteqz = 5'b01100;
    localparam logic [1:0] c_bht_init = 2'b01;

    logic [15:0] r_pc;
    logic [15:0] r_instr;
    logic [15:0] r_pc_id;
    logic [15:0] r_pcplus1;
    logic        r_pred;
    logic [1:0]  r_bht [16];

    logic [15:0] w_fetch;
    logic [4:0]  w_op;
    logic [15:0] w_pcplus1;
    logic        w_is_b;
    logic        w_is_cond;
    logic [1:0]  w_ctr;
    logic        w_pred;
    logic [15:0] w_target;
    logic [15:0] w_next_pc;
    logic        w_redirect;

    // SRAM is only ever read: bus left floating, chip enabled, output enabled
    assign Ram2Data = 16'bz;
    assign Ram2Addr = {2'b00, r_pc};
    assign Ram2OE   = 1'b0;
    assign Ram2WE   = 1'b1;
    assign Ram2EN   = 1'b0;

    assign w_fetch    = Ram2Data;
    assign w_op       = w_fetch[15:11];
    assign w_pcplus1  = r_pc + 16'd1;
    assign w_redirect = prewrong_i | jr_i;

    // Predecode the fetched word; conditional branches consult the BHT entry
    // selected by the low PC bits (old value if an update lands this edge)
    always_comb begin
        w_is_b    = (w_op == c_op_b);
        w_is_cond = (w_op == c_op_beqz) || (w_op == c_op_bnez) ||
                    ((w_op == c_op_bteqz) && (w_fetch[10:8] == 3'b000));
        w_ctr     = r_bht[r_pc[3:0]];
        w_pred    = w_is_b | (w_is_cond & w_ctr[1]);
        if (w_is_b) begin
            w_target = w_pcplus1 + {{5{w_fetch[10]}}, w_fetch[10:0]};
        end else begin
            w_target = w_pcplus1 + {{8{w_fetch[7]}}, w_fetch[7:0]};
        end
    end

    // Next-PC selection: misprediction beats JR beats stall beats prediction
    always_comb begin
        w_next_pc = w_pcplus1;
        if (prewrong_i) begin
            w_next_pc = redirect_pc_i;
        end else if (jr_i) begin
            w_next_pc = jr_target_i;
        end else if (hold_i) begin
            w_next_pc = r_pc;
        end else if (w_pred) begin
            w_next_pc = w_target;
        end
    end

    // PC register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    // IF/ID register: a redirect squashes the wrong-path fetch even under stall
    always_ff @(posedge clk) begin
        if (rst || flush_if_i || w_redirect) begin
            r_instr   <= NOP_INSTR;
            r_pc_id   <= 16'h0000;
            r_pcplus1 <= 16'h0000;
            r_pred    <= 1'b0;
        end else if (!hold_i) begin
            r_instr   <= w_fetch;
            r_pc_id   <= r_pc;
            r_pcplus1 <= w_pcplus1;
            r_pred    <= w_pred;
        end
    end

    // Branch history table: saturating counters trained by resolved branches
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                r_bht[i] <= c_bht_init;
            end
        end else if (bht_upd_i) begin
            if (bht_upd_taken_i) begin
                if (r_bht[bht_upd_idx_i] != 2'b11) begin
                    r_bht[bht_upd_idx_i] <= r_bht[bht_upd_idx_i] + 2'b01;
                end
            end else begin
                if (r_bht[bht_upd_idx_i] != 2'b00) begin
                    r_bht[bht_upd_idx_i] <= r_bht[bht_upd_idx_i] - 2'b01;
                end
            end
        end
    end

    assign instr_o      = r_instr;
    assign pc_o         = r_pc_id;
    assign pcplus1_o    = r_pcplus1;
    assign pred_taken_o = r_pred;

endmodule
`default_nettype wire
